// File: rtl/onehot_enc_pkg.sv
// Shared types, code/select constants and the one-hot encode function for onehot_encoder_pipe.
package onehot_enc_pkg;

    localparam int unsigned CODE_W = 4;
    localparam int unsigned SEL_W  = 3;

    typedef logic [CODE_W-1:0] code_t;
    typedef logic [SEL_W-1:0]  sel_t;

    // Mirrors the 3-bit-select-to-one-hot decoder mapping on the forward path.
    localparam code_t CODE_0 = 4'b0001;
    localparam code_t CODE_1 = 4'b0010;
    localparam code_t CODE_2 = 4'b0100;
    localparam code_t CODE_3 = 4'b1000;

    localparam sel_t SEL_0 = 3'b000;
    localparam sel_t SEL_1 = 3'b001;
    localparam sel_t SEL_2 = 3'b010;
    localparam sel_t SEL_3 = 3'b100;

    typedef struct packed {
        sel_t sel;
        logic err;
    } entry_t;

    typedef enum logic [1:0] {
        EMPTY = 2'd0,
        HALF  = 2'd1,
        FULL  = 2'd2
    } buf_state_e;

    // Zero and multi-hot codes fall through to sel=0 with err set.
    function automatic entry_t encode(input code_t code);
        entry_t e;
        e.sel = SEL_0;
        e.err = 1'b0;
        case (code)
            CODE_0:  e.sel = SEL_0;
            CODE_1:  e.sel = SEL_1;
            CODE_2:  e.sel = SEL_2;
            CODE_3:  e.sel = SEL_3;
            default: e.err = 1'b1;
        endcase
        return e;
    endfunction

endpackage

// File: rtl/onehot_enc_skid.sv
// Two-entry skid buffer for encoded entries; in_ready is a pure state decode, independent of out_ready.
module onehot_enc_skid
    import onehot_enc_pkg::*;
(
    input  logic   clk,
    input  logic   rst_n,
    input  logic   in_valid,
    output logic   in_ready,
    input  entry_t in_data,
    output logic   out_valid,
    input  logic   out_ready,
    output entry_t out_data
);

    buf_state_e state;
    entry_t     skid_q;
    logic       push;
    logic       pop;

    assign push = in_valid && in_ready;
    assign pop  = out_valid && out_ready;

    // out_data is the main (oldest) entry; skid_q only holds a beat while FULL.
    always_ff @(posedge clk) begin
        if (!rst_n) begin
            state     <= EMPTY;
            out_data  <= '0;
            skid_q    <= '0;
            out_valid <= 1'b0;
            in_ready  <= 1'b1;
        end else begin
            unique case (state)
                EMPTY: begin
                    if (push) begin
                        out_data  <= in_data;
                        out_valid <= 1'b1;
                        state     <= HALF;
                    end
                end
                HALF: begin
                    if (push && !pop) begin
                        skid_q   <= in_data;
                        in_ready <= 1'b0;
                        state    <= FULL;
                    end else if (pop && !push) begin
                        out_valid <= 1'b0;
                        state     <= EMPTY;
                    end else if (push && pop) begin
                        out_data <= in_data;
                    end
                end
                FULL: begin
                    if (pop) begin
                        out_data <= skid_q;
                        in_ready <= 1'b1;
                        state    <= HALF;
                    end
                end
                default: begin
                    out_valid <= 1'b0;
                    in_ready  <= 1'b1;
                    state     <= EMPTY;
                end
            endcase
        end
    end

endmodule

// File: rtl/onehot_encoder_pipe.sv
// Registered one-hot to select encoder on valid/ready streams, with illegal-code flagging and counting.
module onehot_encoder_pipe
    import onehot_enc_pkg::*;
#(
    parameter int unsigned CNT_W        = 8,
    parameter bit          DROP_ILLEGAL = 1'b0
) (
    input  logic             clk,
    input  logic             rst_n,
    input  logic             in_valid,
    output logic             in_ready,
    input  logic [3:0]       in_code,
    output logic             out_valid,
    input  logic             out_ready,
    output logic [2:0]       out_sel,
    output logic             out_err,
    input  logic             clr_count,
    output logic [CNT_W-1:0] err_count
);

    localparam logic [CNT_W-1:0] CNT_MAX = '1;

    entry_t enc;
    entry_t head;
    logic   accept;
    logic   illegal_acc;
    logic   skid_valid;

    assign enc         = encode(code_t'(in_code));
    assign accept      = in_valid && in_ready;
    assign illegal_acc = accept && enc.err;
    // Dropped illegal beats still handshake on the input side; they just never reach the buffer.
    assign skid_valid  = in_valid && !(DROP_ILLEGAL && enc.err);

    onehot_enc_skid u_skid (
        .clk       (clk),
        .rst_n     (rst_n),
        .in_valid  (skid_valid),
        .in_ready  (in_ready),
        .in_data   (enc),
        .out_valid (out_valid),
        .out_ready (out_ready),
        .out_data  (head)
    );

    assign out_sel = head.sel;
    assign out_err = head.err;

    // Saturating illegal-code counter; a same-cycle clear and illegal accept leaves 1.
    always_ff @(posedge clk) begin
        if (!rst_n) begin
            err_count <= '0;
        end else if (clr_count) begin
            err_count <= CNT_W'(illegal_acc);
        end else if (illegal_acc && (err_count != CNT_MAX)) begin
            err_count <= err_count + CNT_W'(1);
        end
    end

endmodule

// File: tb/tb_onehot_encoder_pipe.sv
// Scoreboard bench: two instances (forward-illegal/CNT_W=8 and drop-illegal/CNT_W=2) share one stimulus stream.
module tb_onehot_encoder_pipe;

    logic       clk = 1'b0;
    logic       rst_n;
    logic       in_valid;
    logic [3:0] in_code;
    logic       out_ready;
    logic       clr_count;

    logic       in_ready0, out_valid0, out_err0;
    logic [2:0] out_sel0;
    logic [7:0] err_count0;
    logic       in_ready1, out_valid1, out_err1;
    logic [2:0] out_sel1;
    logic [1:0] err_count1;

    int vectors     = 0;
    int miscompares = 0;

    always #5 clk = ~clk;

    onehot_encoder_pipe #(.CNT_W(8), .DROP_ILLEGAL(1'b0)) dut0 (
        .clk(clk), .rst_n(rst_n), .in_valid(in_valid), .in_ready(in_ready0),
        .in_code(in_code), .out_valid(out_valid0), .out_ready(out_ready),
        .out_sel(out_sel0), .out_err(out_err0), .clr_count(clr_count),
        .err_count(err_count0)
    );

    onehot_encoder_pipe #(.CNT_W(2), .DROP_ILLEGAL(1'b1)) dut1 (
        .clk(clk), .rst_n(rst_n), .in_valid(in_valid), .in_ready(in_ready1),
        .in_code(in_code), .out_valid(out_valid1), .out_ready(out_ready),
        .out_sel(out_sel1), .out_err(out_err1), .clr_count(clr_count),
        .err_count(err_count1)
    );

    task automatic chk(input int k, input string nm, input logic [31:0] act, input logic [31:0] exp);
        vectors++;
        if (act !== exp) begin
            miscompares++;
            $display("FAIL dut%0d %s: got %0d expected %0d at %0t", k, nm, act, exp, $time);
        end
    endtask

    // Reference model: each expected beat is stored as sel*2+err, in acceptance order.
    int          sbq[2][$];
    int          mcnt[2];
    int          drop_p[2] = '{0, 1};
    int          max_p[2]  = '{255, 3};
    int          seltab[4] = '{0, 1, 2, 4};
    logic [31:0] a_ov[2], a_ir[2], a_os[2], a_oe[2], a_ec[2];
    bit          chk_en = 1'b0;
    int          occ, ones, msel, head, popped;
    bit          acc, ill, pop;

    initial begin
        forever begin
            @(negedge clk);
            a_ov[0] = 32'(out_valid0); a_ir[0] = 32'(in_ready0); a_os[0] = 32'(out_sel0);
            a_oe[0] = 32'(out_err0);   a_ec[0] = 32'(err_count0);
            a_ov[1] = 32'(out_valid1); a_ir[1] = 32'(in_ready1); a_os[1] = 32'(out_sel1);
            a_oe[1] = 32'(out_err1);   a_ec[1] = 32'(err_count1);
            if (!rst_n) begin
                for (int k = 0; k < 2; k++) begin
                    sbq[k].delete();
                    mcnt[k] = 0;
                end
                chk_en = 1'b1;
            end else if (chk_en) begin
                ones = $countones(in_code);
                ill  = (ones != 1);
                msel = 0;
                for (int p = 0; p < 4; p++)
                    if (!ill && in_code[p]) msel = seltab[p];
                for (int k = 0; k < 2; k++) begin
                    occ = sbq[k].size();
                    chk(k, "out_valid", a_ov[k], 32'(occ > 0));
                    chk(k, "in_ready", a_ir[k], 32'(occ < 2));
                    chk(k, "err_count", a_ec[k], 32'(mcnt[k]));
                    if (occ > 0) begin
                        head = sbq[k][0];
                        chk(k, "out_sel", a_os[k], 32'(head / 2));
                        chk(k, "out_err", a_oe[k], 32'(head % 2));
                    end
                    pop = (occ > 0) && out_ready;
                    acc = in_valid && (occ < 2);
                    if (pop) popped = sbq[k].pop_front();
                    if (acc && (!ill || drop_p[k] == 0))
                        sbq[k].push_back(msel * 2 + (ill ? 1 : 0));
                    if (clr_count)
                        mcnt[k] = (acc && ill) ? 1 : 0;
                    else if (acc && ill && mcnt[k] < max_p[k])
                        mcnt[k]++;
                end
            end
        end
    end

    task automatic drive(input logic r, input logic v, input logic [3:0] c,
                         input logic ordy, input logic clr);
        @(posedge clk);
        #1;
        rst_n     = r;
        in_valid  = v;
        in_code   = c;
        out_ready = ordy;
        clr_count = clr;
    endtask

    logic [3:0] rcode;

    initial begin
        rst_n = 1'b0; in_valid = 1'b0; in_code = 4'b0000; out_ready = 1'b0; clr_count = 1'b0;
        drive(0, 0, 4'b0000, 0, 0);
        drive(0, 0, 4'b0000, 0, 0);
        // Legal codes back to back.
        drive(1, 1, 4'b0001, 1, 0);
        drive(1, 1, 4'b0010, 1, 0);
        drive(1, 1, 4'b0100, 1, 0);
        drive(1, 1, 4'b1000, 1, 0);
        drive(1, 0, 4'b0000, 1, 0);
        drive(1, 0, 4'b0000, 1, 0);
        // Backpressure: fill to FULL, hold a third beat, then release.
        drive(1, 1, 4'b0010, 0, 0);
        drive(1, 1, 4'b1000, 0, 0);
        drive(1, 1, 4'b0001, 0, 0);
        drive(1, 1, 4'b0001, 0, 0);
        drive(1, 1, 4'b0001, 1, 0);
        drive(1, 0, 4'b0000, 1, 0);
        drive(1, 0, 4'b0000, 1, 0);
        drive(1, 0, 4'b0000, 1, 0);
        // Illegal codes: forwarded by dut0, dropped by dut1.
        drive(1, 1, 4'b0000, 1, 0);
        drive(1, 1, 4'b0110, 1, 0);
        drive(1, 1, 4'b0100, 1, 0);
        drive(1, 1, 4'b1111, 1, 0);
        drive(1, 1, 4'b0001, 1, 0);
        drive(1, 0, 4'b0000, 1, 0);
        // Saturation of the 2-bit counter, then clear coinciding with an illegal accept.
        for (int i = 0; i < 5; i++) drive(1, 1, 4'b0011, 1, 0);
        drive(1, 1, 4'b1010, 1, 1);
        drive(1, 0, 4'b0000, 1, 0);
        drive(1, 0, 4'b0000, 1, 1);
        drive(1, 0, 4'b0000, 1, 0);
        // Reset while FULL: no stale beat may appear afterwards.
        drive(1, 1, 4'b0100, 0, 0);
        drive(1, 1, 4'b1100, 0, 0);
        drive(1, 1, 4'b1000, 0, 0);
        drive(0, 0, 4'b0000, 0, 0);
        drive(1, 0, 4'b0000, 1, 0);
        drive(1, 0, 4'b0000, 1, 0);
        drive(1, 0, 4'b0000, 1, 0);
        // Randomized traffic.
        for (int i = 0; i < 3000; i++) begin
            if ($urandom_range(99) < 60) rcode = 4'(4'b0001 << $urandom_range(3));
            else                         rcode = 4'($urandom_range(15));
            drive(($urandom_range(399) != 0),
                  ($urandom_range(99) < 70),
                  rcode,
                  ($urandom_range(99) < 70),
                  ($urandom_range(39) == 0));
        end
        for (int i = 0; i < 4; i++) drive(1, 0, 4'b0000, 1, 0);
        @(negedge clk);
        @(negedge clk);
        $display("== %0d vectors applied, %0d miscompares ==", vectors, miscompares);
        $finish;
    end

endmodule
